// File: rtl/pc_sequencer.sv
// Next-PC sequencer: owns the fetch address, steps it against imem readiness, applies redirects with a flush window, supports stall and halt/resume.
// Latency: every input takes effect on the next rising clk edge; pc_out and all status outputs are registered.
// Backpressure: imem_ready low parks the sequencer in WAIT_MEM and stall holds the PC; a redirect overrides both.
module pc_sequencer #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int                 INCR         = 4,
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_valid,
    output logic              flush,
    output logic              halted
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [3:0]          r_cnt;
    logic                r_pend;
    logic                r_fetch_valid;
    logic                r_flush;
    logic                r_halted;

    state_t              w_nstate;
    logic [ADDR_W-1:0]   w_npc;
    logic [3:0]          w_ncnt;
    logic                w_npend;
    logic [ADDR_W-1:0]   w_tgt;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_halt;

    // Redirect targets are word aligned; the increment wraps naturally at ADDR_W bits.
    assign w_tgt    = {redirect_target[ADDR_W-1:2], 2'b00};
    assign w_pc_inc = r_pc + ADDR_W'(INCR);
    // A halt deferred during a flush acts like a fresh halt request once back in RUN.
    assign w_halt   = halt_req | r_pend;

    // Next-state decode, priority redirect > halt > stall > imem_ready.
    always_comb begin
        w_nstate = r_state;
        w_npc    = r_pc;
        w_ncnt   = r_cnt;
        w_npend  = r_pend;
        case (r_state)
            RUN, WAIT_MEM: begin
                if (redirect_valid) begin
                    w_npc    = w_tgt;
                    w_nstate = FLUSH;
                    w_ncnt   = 4'(FLUSH_CYCLES);
                    if (halt_req) w_npend = 1'b1;
                end else if (w_halt) begin
                    // Any outstanding fetch in WAIT_MEM is simply abandoned.
                    w_nstate = HALTED;
                    w_npend  = 1'b0;
                end else if (r_state == RUN) begin
                    if (!stall) begin
                        if (imem_ready) w_npc    = w_pc_inc;
                        else            w_nstate = WAIT_MEM;
                    end
                end else if (imem_ready) begin
                    w_nstate = RUN;
                    if (!stall) w_npc = w_pc_inc;
                end
            end
            FLUSH: begin
                if (halt_req) w_npend = 1'b1;
                if (redirect_valid) begin
                    w_npc  = w_tgt;
                    w_ncnt = 4'(FLUSH_CYCLES);
                end else if (r_cnt == 4'd1) begin
                    w_nstate = RUN;
                    w_ncnt   = 4'd0;
                end else begin
                    w_ncnt = r_cnt - 4'd1;
                end
            end
            HALTED: begin
                // A redirect while halted only retargets the PC; no flush is needed.
                if (redirect_valid) w_npc = w_tgt;
                if (resume && !halt_req) w_nstate = RUN;
            end
            default: w_nstate = RUN;
        endcase
    end

    // State, PC and Moore outputs registered together so outputs never glitch on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_cnt         <= 4'd0;
            r_pend        <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_nstate;
            r_pc          <= w_npc;
            r_cnt         <= w_ncnt;
            r_pend        <= w_npend;
            r_fetch_valid <= (w_nstate == RUN) || (w_nstate == WAIT_MEM);
            r_flush       <= (w_nstate == FLUSH);
            r_halted      <= (w_nstate == HALTED);
        end
    end

    assign pc_out      = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign flush       = r_flush;
    assign halted      = r_halted;

endmodule
